// File: rtl/axis_arb_pkg.sv
// Shared state encoding, width helper and counter width for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arbState_e;

  localparam int PKT_CNT_WIDTH = 32;

  // Index width for a given number of sources; never narrower than one bit.
  function automatic int clog2Min1(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from lastGrant_i+1,
// wrapping modulo NUM_REQ.
module axis_arb_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] lastGrant_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 found_o
);

  // Rank is the distance past the last winner; the lowest-ranked requester wins.
  always_comb begin
    int rank;
    int bestRank;
    rank     = 0;
    bestRank = NUM_REQ;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = (i + NUM_REQ - 1 - int'(lastGrant_i)) % NUM_REQ;
      if (req_i[i] && (rank < bestRank)) begin
        bestRank = rank;
        idx_o    = IDX_WIDTH'(i);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream master among C_NUM_SOURCES sources.
// Define AXIS_ARB_PKT_COUNT_EN to add the per-source PKT_COUNT output.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  C_NUM_SOURCES = 2,
  parameter int  C_TDATA_WIDTH = 32,
  localparam int C_GRANT_WIDTH = clog2Min1(C_NUM_SOURCES)
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic [C_NUM_SOURCES-1:0]                 S_AXIS_TVALID,
  input  logic [C_NUM_SOURCES*C_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_NUM_SOURCES*C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic [C_NUM_SOURCES-1:0]                 S_AXIS_TLAST,
  output logic [C_NUM_SOURCES-1:0]                 S_AXIS_TREADY,
  output logic                                     M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]               M_AXIS_TKEEP,
  output logic                                     M_AXIS_TLAST,
  input  logic                                     M_AXIS_TREADY,
  output logic [C_GRANT_WIDTH-1:0]                 GRANT,
  output logic                                     GRANT_VALID
`ifdef AXIS_ARB_PKT_COUNT_EN
  ,
  output logic [C_NUM_SOURCES*PKT_CNT_WIDTH-1:0]   PKT_COUNT
`endif
);

  localparam int KEEP_WIDTH = C_TDATA_WIDTH / 8;

  arbState_e                state_q;
  logic [C_GRANT_WIDTH-1:0] grant_q;
  logic [C_GRANT_WIDTH-1:0] lastGrant_q;
  logic                     grantValid_q;

  logic [C_GRANT_WIDTH-1:0] pickIdx;
  logic                     pickFound;
  logic                     lastBeat;

  axis_arb_rr_pick #(
    .NUM_REQ   (C_NUM_SOURCES),
    .IDX_WIDTH (C_GRANT_WIDTH)
  ) u_pick (
    .req_i       (S_AXIS_TVALID),
    .lastGrant_i (lastGrant_q),
    .idx_o       (pickIdx),
    .found_o     (pickFound)
  );

  // Zero-latency passthrough of the owning slice; everything is held at 0 while idle.
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    for (int i = 0; i < C_NUM_SOURCES; i++) begin
      if ((state_q == ST_BUSY) && (grant_q == C_GRANT_WIDTH'(i))) begin
        M_AXIS_TVALID    = S_AXIS_TVALID[i];
        M_AXIS_TDATA     = S_AXIS_TDATA[i*C_TDATA_WIDTH +: C_TDATA_WIDTH];
        M_AXIS_TKEEP     = S_AXIS_TKEEP[i*KEEP_WIDTH +: KEEP_WIDTH];
        M_AXIS_TLAST     = S_AXIS_TLAST[i];
        S_AXIS_TREADY[i] = M_AXIS_TREADY;
      end
    end
  end

  assign lastBeat = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

  // The grant is taken in IDLE and held through every stall until the TLAST handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      lastGrant_q  <= C_GRANT_WIDTH'(C_NUM_SOURCES - 1);
      grantValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pickFound) begin
            grant_q      <= pickIdx;
            lastGrant_q  <= pickIdx;
            grantValid_q <= 1'b1;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lastBeat) begin
            grantValid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          grantValid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign GRANT       = grant_q;
  assign GRANT_VALID = grantValid_q;

`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [PKT_CNT_WIDTH-1:0] pktCount_q [C_NUM_SOURCES];

  // Completed-packet counters per source, free-running with natural wrap.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < C_NUM_SOURCES; i++) begin
        pktCount_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < C_NUM_SOURCES; i++) begin
        if (lastBeat && (grant_q == C_GRANT_WIDTH'(i))) begin
          pktCount_q[i] <= pktCount_q[i] + PKT_CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_SOURCES; g++) begin : gen_pkt_count
    assign PKT_COUNT[g*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = pktCount_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomized bench for axis_pkt_arbiter checked every cycle against a rotating-priority packet model.
// Follows AXIS_ARB_PKT_COUNT_EN: the PKT_COUNT checks exist only when the macro is defined.
module tb_axis_pkt_arbiter;

  localparam int N          = 3;
  localparam int DW         = 32;
  localparam int KW         = DW / 8;
  localparam int GW         = 2;
  localparam int NUM_CYCLES = 5000;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    S_AXIS_TVALID;
  logic [N*DW-1:0] S_AXIS_TDATA;
  logic [N*KW-1:0] S_AXIS_TKEEP;
  logic [N-1:0]    S_AXIS_TLAST;
  logic [N-1:0]    S_AXIS_TREADY;
  logic            M_AXIS_TVALID;
  logic [DW-1:0]   M_AXIS_TDATA;
  logic [KW-1:0]   M_AXIS_TKEEP;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TREADY;
  logic [GW-1:0]   GRANT;
  logic            GRANT_VALID;
`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [N*32-1:0] PKT_COUNT;
`endif

  always #5 ACLK = ~ACLK;

  axis_pkt_arbiter #(
    .C_NUM_SOURCES (N),
    .C_TDATA_WIDTH (DW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TKEEP  (S_AXIS_TKEEP),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .GRANT         (GRANT),
    .GRANT_VALID   (GRANT_VALID)
`ifdef AXIS_ARB_PKT_COUNT_EN
    ,
    .PKT_COUNT     (PKT_COUNT)
`endif
  );

  // Source-side traffic generators.
  logic [N-1:0]  srcValid;
  logic [N-1:0]  srcLast;
  logic [N-1:0]  srcHandshake;
  logic [DW-1:0] srcData [N];
  logic [KW-1:0] srcKeep [N];
  int            beatsLeft [N];
  logic          rstPrev;

  // Reference model: owner is -1 when no packet is in flight.
  int          mdlOwner;
  int          mdlLastGrant;
  int          mdlGrant;
  int unsigned mdlCount [N];

  int checkCount;
  int errorCount;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Phase 0: sources 0/1 stream 3-beat packets back to back. Phase 1: 6-beat packets with
  // M_AXIS_TREADY toggling. Phase 2: random gaps, stalls, lengths and occasional resets.
  task automatic applyStimulus(input int cyc);
    int           lenLo;
    int           lenHi;
    int           validPct;
    int           startPct;
    logic [N-1:0] enable;
    rstPrev = ARESET;
    if (cyc < 400) begin
      enable = 3'b011; lenLo = 3; lenHi = 3; validPct = 100; startPct = 100;
      M_AXIS_TREADY = 1'b1;
      ARESET = 1'b0;
    end else if (cyc < 900) begin
      enable = 3'b111; lenLo = 6; lenHi = 6; validPct = 100; startPct = 100;
      M_AXIS_TREADY = ((cyc % 2) == 0);
      ARESET = 1'b0;
    end else begin
      enable = 3'b111; lenLo = 1; lenHi = 6; validPct = 70; startPct = 40;
      M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      ARESET = ($urandom_range(0, 199) == 0);
    end
    for (int s = 0; s < N; s++) begin
      if (rstPrev) begin
        srcValid[s] = 1'b0;
        srcLast[s] = 1'b0;
        beatsLeft[s] = 0;
      end else if (!(srcValid[s] && !srcHandshake[s])) begin
        srcValid[s] = 1'b0;
        srcLast[s] = 1'b0;
        if (beatsLeft[s] == 0 && enable[s] && $urandom_range(1, 100) <= startPct) begin
          beatsLeft[s] = $urandom_range(lenLo, lenHi);
        end
        if (beatsLeft[s] > 0 && $urandom_range(1, 100) <= validPct) begin
          srcValid[s] = 1'b1;
          srcData[s] = $urandom;
          srcKeep[s] = KW'($urandom);
          srcLast[s] = (beatsLeft[s] == 1);
        end
      end
      S_AXIS_TVALID[s] = srcValid[s];
      S_AXIS_TLAST[s] = srcLast[s];
      S_AXIS_TDATA[s*DW +: DW] = srcData[s];
      S_AXIS_TKEEP[s*KW +: KW] = srcKeep[s];
    end
  endtask

  task automatic checkCycle();
    logic [N-1:0]  expReady;
    logic          expValid;
    logic          expLast;
    logic [DW-1:0] expData;
    logic [KW-1:0] expKeep;
    int            pick;
    expReady = '0;
    expValid = 1'b0;
    expLast = 1'b0;
    expData = '0;
    expKeep = '0;
    if (mdlOwner >= 0) begin
      expValid = srcValid[mdlOwner];
      expLast = srcLast[mdlOwner];
      expData = srcData[mdlOwner];
      expKeep = srcKeep[mdlOwner];
      expReady[mdlOwner] = M_AXIS_TREADY;
    end
    checkOutput("M_TVALID", M_AXIS_TVALID, expValid);
    checkOutput("M_TLAST", M_AXIS_TLAST, expLast);
    checkOutput("M_TDATA", M_AXIS_TDATA, expData);
    checkOutput("M_TKEEP", M_AXIS_TKEEP, expKeep);
    checkOutput("S_TREADY", S_AXIS_TREADY, expReady);
    checkOutput("GRANT", GRANT, mdlGrant);
    checkOutput("GRANT_VALID", GRANT_VALID, mdlOwner >= 0);
`ifdef AXIS_ARB_PKT_COUNT_EN
    for (int s = 0; s < N; s++) begin
      checkOutput($sformatf("PKT_COUNT[%0d]", s), PKT_COUNT[s*32 +: 32], mdlCount[s]);
    end
`endif
    for (int s = 0; s < N; s++) begin
      srcHandshake[s] = srcValid[s] & S_AXIS_TREADY[s];
      if (srcHandshake[s] && beatsLeft[s] > 0) begin
        beatsLeft[s]--;
      end
    end
    if (ARESET) begin
      mdlOwner = -1;
      mdlLastGrant = N - 1;
      mdlGrant = 0;
      for (int s = 0; s < N; s++) mdlCount[s] = 0;
    end else if (mdlOwner < 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && srcValid[(mdlLastGrant + k) % N]) pick = (mdlLastGrant + k) % N;
      end
      if (pick >= 0) begin
        mdlOwner = pick;
        mdlLastGrant = pick;
        mdlGrant = pick;
      end
    end else if (srcValid[mdlOwner] && M_AXIS_TREADY && srcLast[mdlOwner]) begin
      mdlCount[mdlOwner]++;
      mdlOwner = -1;
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    ARESET = 1'b1;
    rstPrev = 1'b1;
    M_AXIS_TREADY = 1'b0;
    S_AXIS_TVALID = '0;
    S_AXIS_TLAST = '0;
    S_AXIS_TDATA = '0;
    S_AXIS_TKEEP = '0;
    srcValid = '0;
    srcLast = '0;
    srcHandshake = '0;
    for (int s = 0; s < N; s++) begin
      srcData[s] = '0;
      srcKeep[s] = '0;
      beatsLeft[s] = 0;
      mdlCount[s] = 0;
    end
    mdlOwner = -1;
    mdlLastGrant = N - 1;
    mdlGrant = 0;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checkCycle();
    @(posedge ACLK);
    #1;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      applyStimulus(cyc);
      @(negedge ACLK);
      checkCycle();
      @(posedge ACLK);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master port among `C_NUM_SOURCES` AXI-Stream sources, such as several `net2axis` packet generators feeding one DUT. A source keeps the grant from its first beat until its `TLAST` beat, so packets are never interleaved. It is the sequencing stage between the stimulus generators and the device under test in the simulation and FPGA test harnesses.

## Interface
Parameters:
- `C_NUM_SOURCES`, 2: number of slave ports, 2..16.
- `C_TDATA_WIDTH`, 32: data width in bits, a multiple of 8.
- `C_GRANT_WIDTH`, derived as clog2(`C_NUM_SOURCES`), minimum 1. Localparam, not overridable.

Ports:
- `ACLK`  in  1  clock; all logic is rising-edge.
- `ARESET`  in  1  reset. Synchronous, active-high.
- `S_AXIS_TVALID`  in  `C_NUM_SOURCES`  per-source valid.
- `S_AXIS_TDATA`  in  `C_NUM_SOURCES*C_TDATA_WIDTH`  per-source data, source i in slice i.
- `S_AXIS_TKEEP`  in  `C_NUM_SOURCES*C_TDATA_WIDTH/8`  per-source byte keep.
- `S_AXIS_TLAST`  in  `C_NUM_SOURCES`  per-source end of packet.
- `S_AXIS_TREADY`  out  `C_NUM_SOURCES`  per-source ready.
- `M_AXIS_TVALID`  out  1  output valid.
- `M_AXIS_TDATA`  out  `C_TDATA_WIDTH`  output data.
- `M_AXIS_TKEEP`  out  `C_TDATA_WIDTH/8`  output keep.
- `M_AXIS_TLAST`  out  1  output end of packet.
- `M_AXIS_TREADY`  in  1  downstream ready.
- `GRANT`  out  `C_GRANT_WIDTH`  index of the source currently owning the output.
- `GRANT_VALID`  out  1  high while a packet is being forwarded (state BUSY).

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - All `S_AXIS_TREADY` are 0.
  - `M_AXIS_TVALID`, `M_AXIS_TDATA`, `M_AXIS_TKEEP` and `M_AXIS_TLAST` are 0.
  - If any `S_AXIS_TVALID` is high, the arbiter picks the first requester searching upward from `last_grant+1`, wrapping modulo `C_NUM_SOURCES`. It registers that index in `GRANT` and `last_grant`, and the FSM moves to BUSY.
- BUSY:
  - The output equals the granted slice: `M_AXIS_TVALID/TDATA/TKEEP/TLAST`.
  - `S_AXIS_TREADY[GRANT] = M_AXIS_TREADY`. All other readies are 0.
  - The path from inputs to outputs is combinational (zero-latency passthrough).
  - On a beat with `M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST`, the FSM moves to IDLE.
- If the granted source drops `TVALID` mid-packet, the grant holds and the output waits. The arbiter never times out.
- Requests from other sources during BUSY are ignored until the FSM returns to IDLE. Sources must keep `TVALID` asserted per AXI-Stream rules.
- `TDATA` is not inspected or modified.

## Timing
- Reset values:
  - State is IDLE.
  - `GRANT` is 0 and `GRANT_VALID` is 0.
  - `last_grant` is `C_NUM_SOURCES-1`, so source 0 wins first.
  - All `S_AXIS_TREADY` are 0 and all `M_AXIS_*` outputs are 0.
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N means BUSY and the first transfer is possible at edge N+1.
- There is exactly one IDLE cycle between consecutive packets, so peak throughput is L/(L+1) for L-beat packets.
- A single-beat packet (first beat has `TLAST`) takes 1 BUSY cycle plus 1 IDLE cycle.
- Simultaneous requests are resolved strictly by rotating priority. With all sources requesting continuously, grants cycle 0,1,…,N-1,0.
- `ARESET` asserted in BUSY returns the FSM to IDLE on the next edge. The partial packet is truncated with no `TLAST` generated, and `last_grant` is reset.
- `M_AXIS_TREADY` may toggle at any time in BUSY. Stalls pass straight through.

## Configuration
- `AXIS_ARB_PKT_COUNT_EN`
  - Defined: adds output `PKT_COUNT` (`C_NUM_SOURCES*32`). Slice i increments on each `TLAST` handshake from source i, wraps at 2^32, and resets to 0.
  - Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `axis_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_BUSY`)
  - the clog2 function with minimum 1
  - the counter width constant (32)
- Sub-module `axis_arb_rr_pick` is a combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are the index and the found flag.

## Test plan
- Reset, then source 0 sends a 4-beat packet with `M_AXIS_TREADY=1`:
  - `GRANT=0` one cycle after `TVALID`.
  - 4 beats appear on M with data unchanged.
  - `TLAST` on beat 4, then one IDLE cycle.
- Sources 0 and 1 both request continuously with 3-beat packets:
  - Output order is packet 0, 1, 0, 1.
  - Never interleaved.
  - One-cycle gap between packets.
- `M_AXIS_TREADY` toggles 1010… during a 6-beat packet:
  - Exactly 6 transfers occur.
  - `S_AXIS_TREADY` of the granted source mirrors `M_AXIS_TREADY`.
  - Other readies stay 0.
- Granted source drops `TVALID` for 5 cycles mid-packet while source 1 requests:
  - `GRANT` stays fixed.
  - Source 1 is granted only after source 0's `TLAST`.
- `ARESET` is pulsed on beat 2 of a 5-beat packet:
  - Next cycle, all outputs are 0 and the FSM is IDLE.
  - Next arbitration grants source 0.
- With `AXIS_ARB_PKT_COUNT_EN` defined, send 3 packets on source 1 and 2 on source 0:
  - `PKT_COUNT` slices read 2 and 3.
